elevator_scheduler: RTL and testbench

- Central sequencing FSM for the 4-storey elevator controller.
- Latches floor requests and picks the travel direction using a SCAN policy: keep going while requests remain ahead, otherwise reverse.
- Sequences the run timer through mv2nxt/endRun and the door timer through opendoor/endOpen, and tracks the current floor.
- Sits between the button inputs and the run/door timers. Runs on the low-frequency controller clock.

---
 rtl/elevator_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_scheduler
// Central sequencing FSM for a 4-storey elevator controller. It latches floor
// calls, picks the travel direction with a SCAN policy, drives the run timer
// (mv2nxt/endRun) and the door timer (opendoor/endOpen), and tracks the floor.
//
// Ports:
//   CP        in   1  controller clock, rising edge
//   nCR       in   1  asynchronous active-low reset
//   req       in   4  floor call buttons, one bit per floor (level)
//   endRun    in   1  run-timer done (may be held for several cycles)
//   endOpen   in   1  door-timer done
//   mv2nxt    out  1  run-timer enable (RUN and ARRIVE)
//   opendoor  out  1  door-timer enable (DOOR)
//   floor     out  2  current floor 0..3
//   dir       out  1  1 = up, 0 = down
//   pend      out  4  latched pending requests
//   busy      out  1  state is not IDLE
//
// Optional feature: define HOME_RETURN_EN to return the car to HOME_FLOOR
// after IDLE_TICKS idle cycles with nothing pending. Without the macro the
// car stays at its last floor indefinitely.
// ---------------------------------------------------------------------------
module elevator_scheduler #(
   parameter int unsigned HOME_FLOOR = 0,
   parameter int unsigned IDLE_TICKS = 32
) (
   input  logic       CP,
   input  logic       nCR,
   input  logic [3:0] req,
   input  logic       endRun,
   input  logic       endOpen,
   output logic       mv2nxt,
   output logic       opendoor,
   output logic [1:0] floor,
   output logic       dir,
   output logic [3:0] pend,
   output logic       busy
);

   localparam int unsigned NUM_FLOORS = 4;
   localparam int unsigned FLOOR_W    = 2;
   localparam int unsigned CNT_W      = 8;

   localparam logic [FLOOR_W-1:0] HOME_FL   = FLOOR_W'(HOME_FLOOR);
   localparam logic [CNT_W-1:0]   TICKS     = CNT_W'(IDLE_TICKS);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_ARRIVE = 2'd2,
      S_DOOR   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [FLOOR_W-1:0]      floor_q, floor_d;
   logic                    dir_q, dir_d;
   logic [NUM_FLOORS-1:0]   pend_q, pend_d;
   logic                    endrun_q, endopen_q;
   logic                    mv2nxt_q, mv2nxt_d;
   logic                    opendoor_q, opendoor_d;
   logic                    busy_q, busy_d;

   logic                    run_ev, open_ev;
   logic [NUM_FLOORS-1:0]   clr, above, below;
   logic                    at_floor, any_above, any_below, ahead;
   logic                    at_top, at_bot;

`ifdef HOME_RETURN_EN
   logic [CNT_W-1:0]        idle_cnt_q, idle_cnt_d;
   logic                    home_q, home_d;
`else
   logic                    unused_cfg;
   assign unused_cfg = ^{HOME_FL, TICKS};
`endif

   // Rising-edge events of the timer done flags
   assign run_ev  = endRun  & ~endrun_q;
   assign open_ev = endOpen & ~endopen_q;

   // Request latch; the door clears its own floor and wins over a new set
   always_comb begin
      clr = '0;
      if (state_q == S_DOOR) begin
         clr = NUM_FLOORS'(1) << floor_q;
      end
      pend_d = (pend_q | req) & ~clr;
   end

   // Pending requests strictly above / below the car
   always_comb begin
      above = '0;
      below = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         above[i] = pend_q[i] && (FLOOR_W'(i) > floor_q);
         below[i] = pend_q[i] && (FLOOR_W'(i) < floor_q);
      end
   end

   assign at_floor  = pend_q[floor_q];
   assign any_above = |above;
   assign any_below = |below;
   assign ahead     = dir_q ? any_above : any_below;
   assign at_top    = (floor_q == TOP_FLOOR);
   assign at_bot    = (floor_q == '0);

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      floor_d = floor_q;
      dir_d   = dir_q;
`ifdef HOME_RETURN_EN
      idle_cnt_d = '0;
      home_d     = home_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            // Current floor first, then keep the current direction
            if (at_floor) begin
               state_d = S_DOOR;
            end else if ((dir_q && any_above) || (!dir_q && !any_below && any_above)) begin
               dir_d   = 1'b1;
               state_d = S_RUN;
            end else if (any_below) begin
               dir_d   = 1'b0;
               state_d = S_RUN;
`ifdef HOME_RETURN_EN
            end else if (floor_q != HOME_FL) begin
               // Nothing pending here: count toward the home-return trip
               idle_cnt_d = idle_cnt_q + CNT_W'(1);
               if (idle_cnt_d == TICKS) begin
                  idle_cnt_d = '0;
                  dir_d      = (HOME_FL > floor_q);
                  home_d     = 1'b1;
                  state_d    = S_RUN;
               end
`endif
            end
         end

         S_RUN: begin
            if (run_ev) begin
               // A move past either end is dropped and the car settles
               if ((dir_q && at_top) || (!dir_q && at_bot)) begin
                  state_d = S_IDLE;
`ifdef HOME_RETURN_EN
                  home_d  = 1'b0;
`endif
               end else begin
                  floor_d = dir_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
                  state_d = S_ARRIVE;
               end
            end
         end

         // Decide on the freshly updated floor
         S_ARRIVE: begin
            if (at_floor) begin
               state_d = S_DOOR;
`ifdef HOME_RETURN_EN
               home_d  = 1'b0;
`endif
            end else if (ahead) begin
               state_d = S_RUN;
`ifdef HOME_RETURN_EN
            end else if (home_q && (floor_q != HOME_FL)) begin
               state_d = S_RUN;
`endif
            end else begin
               state_d = S_IDLE;
`ifdef HOME_RETURN_EN
               home_d  = 1'b0;
`endif
            end
         end

         S_DOOR: begin
            if (open_ev) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      mv2nxt_d   = (state_d == S_RUN) || (state_d == S_ARRIVE);
      opendoor_d = (state_d == S_DOOR);
      busy_d     = (state_d != S_IDLE);
   end

   // State and datapath registers
   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         state_q    <= S_IDLE;
         floor_q    <= '0;
         dir_q      <= 1'b1;
         pend_q     <= '0;
         endrun_q   <= 1'b0;
         endopen_q  <= 1'b0;
         mv2nxt_q   <= 1'b0;
         opendoor_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef HOME_RETURN_EN
         idle_cnt_q <= '0;
         home_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         floor_q    <= floor_d;
         dir_q      <= dir_d;
         pend_q     <= pend_d;
         endrun_q   <= endRun;
         endopen_q  <= endOpen;
         mv2nxt_q   <= mv2nxt_d;
         opendoor_q <= opendoor_d;
         busy_q     <= busy_d;
`ifdef HOME_RETURN_EN
         idle_cnt_q <= idle_cnt_d;
         home_q     <= home_d;
`endif
      end
   end

   assign mv2nxt   = mv2nxt_q;
   assign opendoor = opendoor_q;
   assign floor    = floor_q;
   assign dir      = dir_q;
   assign pend     = pend_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// ---------------------------------------------------------------------------
// tb_elevator_scheduler
// Directed scenarios for elevator_scheduler. The driver pushes the expected
// output snapshot and the clock edge it must appear on; the monitor pops an
// entry every time the observed output vector changes and compares both.
// ---------------------------------------------------------------------------
module tb_elevator_scheduler;

   logic       CP = 1'b0;
   logic       nCR = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       endRun = 1'b0;
   logic       endOpen = 1'b0;
   logic       mv2nxt, opendoor, dir, busy;
   logic [1:0] floor;
   logic [3:0] pend;

`ifdef HOME_RETURN_EN
   elevator_scheduler #(.HOME_FLOOR(0), .IDLE_TICKS(4)) dut (
`else
   elevator_scheduler dut (
`endif
      .CP(CP), .nCR(nCR), .req(req), .endRun(endRun), .endOpen(endOpen),
      .mv2nxt(mv2nxt), .opendoor(opendoor), .floor(floor), .dir(dir),
      .pend(pend), .busy(busy)
   );

   always #5 CP = ~CP;

   int cyc = 0;
   always @(posedge CP) cyc <= cyc + 1;

   typedef struct {
      string      name;
      int         cyc;   // -1: edge not checked
      logic [9:0] vec;   // {mv2nxt, opendoor, floor, dir, pend, busy}
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic exp_at(input string nm, input int c, input logic mv, input logic od,
                         input logic [1:0] fl, input logic dr, input logic [3:0] pd,
                         input logic bz);
      exp_t e;
      e.name = nm;
      e.cyc  = c;
      e.vec  = {mv, od, fl, dr, pd, bz};
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CP);
      #1;
   endtask

   task automatic goto_cyc(input int c);
      while (cyc < c) step(1);
   endtask

   // endRun held for two cycles
   task automatic run_pulse(input int c);
      goto_cyc(c);
      endRun = 1'b1;
      goto_cyc(c + 2);
      endRun = 1'b0;
   endtask

   task automatic door_close(input int c);
      goto_cyc(c);
      endOpen = 1'b1;
      goto_cyc(c + 1);
      endOpen = 1'b0;
   endtask

   // Monitor: compare on every change of the output vector
   initial begin : monitor
      logic [9:0] cur, prev;
      bit         first;
      exp_t       e;
      first = 1'b1;
      prev  = '0;
      forever begin
         @(negedge CP);
         cur = {mv2nxt, opendoor, floor, dir, pend, busy};
         if (first || cur !== prev) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change: got=%b@%0d want=no change", cur, cyc);
            end else begin
               e = q.pop_front();
               if (cur !== e.vec || (e.cyc >= 0 && e.cyc != cyc)) begin
                  bad++;
                  $display("FAIL %s: got=%b@%0d want=%b@%0d", e.name, cur, cyc, e.vec, e.cyc);
               end
            end
         end
         prev  = cur;
         first = 1'b0;
      end
   end

   initial begin : driver
      int b;
      exp_at("reset_state", -1, 0, 0, 2'd0, 1, 4'b0000, 0);
      #1 nCR = 1'b0;
      step(2);
      nCR = 1'b1;
      step(1);

      // Call at the current floor: door opens on the 2nd edge, car never moves
      b = cyc;
      exp_at("p1_latch", b+1, 0, 0, 2'd0, 1, 4'b0001, 0);
      exp_at("p1_door",  b+2, 0, 1, 2'd0, 1, 4'b0001, 1);
      exp_at("p1_clr",   b+3, 0, 1, 2'd0, 1, 4'b0000, 1);
      exp_at("p1_idle",  b+5, 0, 0, 2'd0, 1, 4'b0000, 0);
      req = 4'b0001; goto_cyc(b+1); req = 4'b0000;
      door_close(b+4);

      // Floor 0 to 3, one floor per held endRun pulse
      b = cyc;
      exp_at("p2_latch", b+1,  0, 0, 2'd0, 1, 4'b1000, 0);
      exp_at("p2_run",   b+2,  1, 0, 2'd0, 1, 4'b1000, 1);
      exp_at("p2_f1",    b+4,  1, 0, 2'd1, 1, 4'b1000, 1);
      exp_at("p2_f2",    b+7,  1, 0, 2'd2, 1, 4'b1000, 1);
      exp_at("p2_f3",    b+10, 1, 0, 2'd3, 1, 4'b1000, 1);
      exp_at("p2_door",  b+11, 0, 1, 2'd3, 1, 4'b1000, 1);
      exp_at("p2_clr",   b+12, 0, 1, 2'd3, 1, 4'b0000, 1);
      exp_at("p2_idle",  b+14, 0, 0, 2'd3, 1, 4'b0000, 0);
      req = 4'b1000; goto_cyc(b+1); req = 4'b0000;
      run_pulse(b+3); run_pulse(b+6); run_pulse(b+9);
      door_close(b+13);

      // Floor 3 down to 1
      b = cyc;
      exp_at("p3a_latch", b+1,  0, 0, 2'd3, 1, 4'b0010, 0);
      exp_at("p3a_run",   b+2,  1, 0, 2'd3, 0, 4'b0010, 1);
      exp_at("p3a_f2",    b+4,  1, 0, 2'd2, 0, 4'b0010, 1);
      exp_at("p3a_f1",    b+7,  1, 0, 2'd1, 0, 4'b0010, 1);
      exp_at("p3a_door",  b+8,  0, 1, 2'd1, 0, 4'b0010, 1);
      exp_at("p3a_clr",   b+9,  0, 1, 2'd1, 0, 4'b0000, 1);
      exp_at("p3a_idle",  b+11, 0, 0, 2'd1, 0, 4'b0000, 0);
      req = 4'b0010; goto_cyc(b+1); req = 4'b0000;
      run_pulse(b+3); run_pulse(b+6);
      door_close(b+10);

      // Up from 1 with pend=1001: pass 2, serve 3, reverse to 0
      b = cyc;
      exp_at("p3b_latch", b+1,  0, 0, 2'd1, 0, 4'b1000, 0);
      exp_at("p3b_run",   b+2,  1, 0, 2'd1, 1, 4'b1001, 1);
      exp_at("p3b_f2",    b+4,  1, 0, 2'd2, 1, 4'b1001, 1);
      exp_at("p3b_f3",    b+7,  1, 0, 2'd3, 1, 4'b1001, 1);
      exp_at("p3b_door3", b+8,  0, 1, 2'd3, 1, 4'b1001, 1);
      exp_at("p3b_clr3",  b+9,  0, 1, 2'd3, 1, 4'b0001, 1);
      exp_at("p3b_idle3", b+11, 0, 0, 2'd3, 1, 4'b0001, 0);
      exp_at("p3b_rev",   b+12, 1, 0, 2'd3, 0, 4'b0001, 1);
      exp_at("p3b_d2",    b+14, 1, 0, 2'd2, 0, 4'b0001, 1);
      exp_at("p3b_d1",    b+17, 1, 0, 2'd1, 0, 4'b0001, 1);
      exp_at("p3b_d0",    b+20, 1, 0, 2'd0, 0, 4'b0001, 1);
      exp_at("p3b_door0", b+21, 0, 1, 2'd0, 0, 4'b0001, 1);
      exp_at("p3b_clr0",  b+22, 0, 1, 2'd0, 0, 4'b0000, 1);
      exp_at("p3b_idle0", b+24, 0, 0, 2'd0, 0, 4'b0000, 0);
      req = 4'b1000; goto_cyc(b+1); req = 4'b0001; goto_cyc(b+2); req = 4'b0000;
      run_pulse(b+3); run_pulse(b+6);
      door_close(b+10);
      run_pulse(b+13); run_pulse(b+16); run_pulse(b+19);
      door_close(b+23);

      // Call at floor 2 held during DOOR is absorbed
      b = cyc;
      exp_at("p4_latch", b+1,  0, 0, 2'd0, 0, 4'b0100, 0);
      exp_at("p4_run",   b+2,  1, 0, 2'd0, 1, 4'b0100, 1);
      exp_at("p4_f1",    b+4,  1, 0, 2'd1, 1, 4'b0100, 1);
      exp_at("p4_f2",    b+7,  1, 0, 2'd2, 1, 4'b0100, 1);
      exp_at("p4_door",  b+8,  0, 1, 2'd2, 1, 4'b0100, 1);
      exp_at("p4_clr",   b+9,  0, 1, 2'd2, 1, 4'b0000, 1);
      exp_at("p4_idle",  b+13, 0, 0, 2'd2, 1, 4'b0000, 0);
      req = 4'b0100; goto_cyc(b+1); req = 4'b0000;
      run_pulse(b+3); run_pulse(b+6);
      req = 4'b0100;
      goto_cyc(b+12);
      req = 4'b0000; endOpen = 1'b1;
      goto_cyc(b+13);
      endOpen = 1'b0;

      // Reset asserted between edges while running at floor 2
      b = cyc;
      exp_at("p5_latch",   b+1, 0, 0, 2'd2, 1, 4'b0001, 0);
      exp_at("p5_run",     b+2, 1, 0, 2'd2, 0, 4'b0001, 1);
      exp_at("p5_async",   b+4, 0, 0, 2'd0, 1, 4'b0000, 0);
      req = 4'b0001; goto_cyc(b+1); req = 4'b0000;
      goto_cyc(b+3);
      @(posedge CP); #1;
      nCR = 1'b0;
      goto_cyc(b+5);
      nCR = 1'b1;

      // Normal service after reset
      b = cyc;
      exp_at("p7_latch", b+1, 0, 0, 2'd0, 1, 4'b0001, 0);
      exp_at("p7_door",  b+2, 0, 1, 2'd0, 1, 4'b0001, 1);
      exp_at("p7_clr",   b+3, 0, 1, 2'd0, 1, 4'b0000, 1);
      exp_at("p7_idle",  b+5, 0, 0, 2'd0, 1, 4'b0000, 0);
      req = 4'b0001; goto_cyc(b+1); req = 4'b0000;
      door_close(b+4);

`ifdef HOME_RETURN_EN
      // Idle at floor 2 returns home after 4 cycles with the door shut
      b = cyc;
      exp_at("p6_latch", b+1,  0, 0, 2'd0, 1, 4'b0100, 0);
      exp_at("p6_run",   b+2,  1, 0, 2'd0, 1, 4'b0100, 1);
      exp_at("p6_f1",    b+4,  1, 0, 2'd1, 1, 4'b0100, 1);
      exp_at("p6_f2",    b+7,  1, 0, 2'd2, 1, 4'b0100, 1);
      exp_at("p6_door",  b+8,  0, 1, 2'd2, 1, 4'b0100, 1);
      exp_at("p6_clr",   b+9,  0, 1, 2'd2, 1, 4'b0000, 1);
      exp_at("p6_idle",  b+11, 0, 0, 2'd2, 1, 4'b0000, 0);
      exp_at("p6_home",  b+15, 1, 0, 2'd2, 0, 4'b0000, 1);
      exp_at("p6_h1",    b+17, 1, 0, 2'd1, 0, 4'b0000, 1);
      exp_at("p6_h0",    b+20, 1, 0, 2'd0, 0, 4'b0000, 1);
      exp_at("p6_park",  b+21, 0, 0, 2'd0, 0, 4'b0000, 0);
      req = 4'b0100; goto_cyc(b+1); req = 4'b0000;
      run_pulse(b+3); run_pulse(b+6);
      door_close(b+10);
      run_pulse(b+16); run_pulse(b+19);
      goto_cyc(b+22);
`endif

      step(4);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL missing_changes: got=%0d entries left want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
